if_stage: RTL and testbench

Instruction fetch stage. It drives the PC/instruction interface consumed by the decode stage and honours the pipeline stall and branch/jump redirect (load-new-PC) signals. It fetches 32-bit words from an instruction memory over a request/grant/response handshake with variable latency. Empty slots are inserted as all-zero bubbles, which the decode stage treats as opcode 0.

---
 rtl/if_stage.sv | 155 +++++++++++++++
 tb/tb_if_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: request/grant/response fetch with a one-entry skid buffer,
// stall hold, and branch/jump redirect with drop of a stale in-flight response.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pipeline_stall,
    input  logic        i_load_new_pc,
    input  logic [31:0] i_new_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_instruction,
    output logic        o_instr_valid
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic        drop, drop_n;
    logic        buf_valid, buf_valid_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] instr_q, instr_n;
    logic        valid_q, valid_n;

    logic        handshake;
    logic        resp_take;
    logic        in_flight;
    logic [31:0] resp_pc;
    logic [31:0] new_target;

    // The request line is held low while reset is asserted even though state sits in REQ.
    assign o_imem_req  = !reset && (state == S_REQ) && !buf_valid;
    assign o_imem_addr = reset ? RESET_PC : fetch_pc;

    assign handshake  = o_imem_req && i_imem_gnt;
    assign resp_take  = (state == S_WAIT) && i_imem_rvalid && !drop;
    assign resp_pc    = fetch_pc - 32'd4;
    assign new_target = i_new_pc & ~32'd3;
    // A request still unanswered after this cycle must have its response dropped on redirect.
    assign in_flight  = handshake || ((state == S_WAIT) && !i_imem_rvalid);

    assign o_pc          = pc_q;
    assign o_instruction = instr_q;
    assign o_instr_valid = valid_q;

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        drop_n      = drop;
        buf_valid_n = buf_valid;
        buf_pc_n    = buf_pc;
        buf_instr_n = buf_instr;
        pc_n        = pc_q;
        instr_n     = instr_q;
        valid_n     = valid_q;

        if (i_load_new_pc) begin
            pc_n        = 32'h0;
            instr_n     = 32'h0;
            valid_n     = 1'b0;
            buf_valid_n = 1'b0;
            fetch_pc_n  = new_target;
            if (in_flight) begin
                drop_n  = 1'b1;
                state_n = S_WAIT;
            end else begin
                drop_n  = 1'b0;
                state_n = S_REQ;
            end
        end else begin
            if (!i_pipeline_stall) begin
                if (buf_valid) begin
                    pc_n        = buf_pc;
                    instr_n     = buf_instr;
                    valid_n     = 1'b1;
                    buf_valid_n = resp_take;
                    if (resp_take) begin
                        buf_pc_n    = resp_pc;
                        buf_instr_n = i_imem_rdata;
                    end
                end else if (resp_take) begin
                    pc_n    = resp_pc;
                    instr_n = i_imem_rdata;
                    valid_n = 1'b1;
                end else begin
                    pc_n    = 32'h0;
                    instr_n = 32'h0;
                    valid_n = 1'b0;
                end
            end else if (resp_take) begin
                buf_valid_n = 1'b1;
                buf_pc_n    = resp_pc;
                buf_instr_n = i_imem_rdata;
            end

            case (state)
                S_REQ: begin
                    if (handshake) begin
                        fetch_pc_n = fetch_pc + 32'd4;
                        state_n    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = S_REQ;
                        end else begin
                            state_n = buf_valid_n ? S_HOLD : S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!buf_valid_n) state_n = S_REQ;
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_REQ;
            fetch_pc  <= RESET_PC;
            drop      <= 1'b0;
            buf_valid <= 1'b0;
            buf_pc    <= 32'h0;
            buf_instr <= 32'h0;
            pc_q      <= 32'h0;
            instr_q   <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            drop      <= drop_n;
            buf_valid <= buf_valid_n;
            buf_pc    <= buf_pc_n;
            buf_instr <= buf_instr_n;
            pc_q      <= pc_n;
            instr_q   <= instr_n;
            valid_q   <= valid_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table, hand-written reset/redirect sequences,
// and a randomized run checked against a transaction-level fetch-stream model.
module tb_if_stage;

    localparam logic [31:0] RST = 32'h0000_0200;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        load;
    logic [31:0] new_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(.RESET_PC(RST)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_pipeline_stall (stall),
        .i_load_new_pc    (load),
        .i_new_pc         (new_pc),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_gnt       (gnt),
        .i_imem_rvalid    (rvalid),
        .i_imem_rdata     (rdata),
        .o_pc             (pc),
        .o_instruction    (instruction),
        .o_instr_valid    (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        load;
        logic [31:0] new_pc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    // Memory contents: every word is derived from its own address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] a, input logic g, input logic rv,
                                input logic [31:0] rd, input logic st, input logic ld,
                                input logic [31:0] np, input logic ev, input logic [31:0] ep,
                                input logic [31:0] ei);
        vec_t v;
        v.exp_req = r;   v.exp_addr = a;  v.gnt = g;      v.rvalid = rv;  v.rdata = rd;
        v.stall = st;    v.load = ld;     v.new_pc = np;  v.exp_valid = ev;
        v.exp_pc = ep;   v.exp_instr = ei;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        gnt = v.gnt; rvalid = v.rvalid; rdata = v.rdata;
        stall = v.stall; load = v.load; new_pc = v.new_pc;
        #1;
        checkOutput({tag, " req"}, {31'h0, imem_req}, {31'h0, v.exp_req});
        if (v.exp_req) checkOutput({tag, " addr"}, imem_addr, v.exp_addr);
        @(posedge clk);
        #1;
        checkOutput({tag, " valid"}, {31'h0, instr_valid}, {31'h0, v.exp_valid});
        checkOutput({tag, " pc"}, pc, v.exp_pc);
        checkOutput({tag, " instr"}, instruction, v.exp_instr);
    endtask

    task automatic idleInputs();
        gnt = 0; rvalid = 0; rdata = 0; stall = 0; load = 0; new_pc = 0;
    endtask

    // Random-phase model state
    logic [31:0] exp_req_addr, exp_out_pc, out_addr;
    logic [31:0] held_pc, held_instr;
    logic        held_valid, prev_stall, prev_load, outstanding, busy;
    int          lat, valid_seen;
    logic [31:0] B;

    initial begin
        B = RST;
        idleInputs();
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset req low", {31'h0, imem_req}, 32'h0);
        checkOutput("reset addr", imem_addr, RST);
        @(posedge clk); #1;
        checkOutput("reset valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("reset pc", pc, 32'h0);
        checkOutput("reset instr", instruction, 32'h0);
        reset = 1'b0;

        // exp_req, exp_addr, gnt, rvalid, rdata, stall, load, new_pc, exp_valid, exp_pc, exp_instr
        vecs.push_back(mk(1, B,        1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(B), 0, 0, 0, 1, B, word(B)));
        vecs.push_back(mk(1, B+4,      1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(B+4), 0, 0, 0, 1, B+4, word(B+4)));
        vecs.push_back(mk(1, B+8,      1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(B+8), 0, 0, 0, 1, B+8, word(B+8)));
        vecs.push_back(mk(1, B+'hC,    0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, B+'hC,    1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(B+'hC), 0, 0, 0, 1, B+'hC, word(B+'hC)));
        // stall for four cycles while the 0x10 response lands in the skid buffer
        vecs.push_back(mk(1, B+'h10,   1, 0, 0, 1, 0, 0, 1, B+'hC, word(B+'hC)));
        vecs.push_back(mk(0, 0,        0, 1, word(B+'h10), 1, 0, 0, 1, B+'hC, word(B+'hC)));
        vecs.push_back(mk(0, 0,        1, 0, 0, 1, 0, 0, 1, B+'hC, word(B+'hC)));
        vecs.push_back(mk(0, 0,        1, 0, 0, 1, 0, 0, 1, B+'hC, word(B+'hC)));
        vecs.push_back(mk(0, 0,        1, 0, 0, 0, 0, 0, 1, B+'h10, word(B+'h10)));
        vecs.push_back(mk(1, B+'h14,   1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(B+'h14), 0, 0, 0, 1, B+'h14, word(B+'h14)));
        vecs.push_back(mk(1, B+'h18,   1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(B+'h18), 0, 0, 0, 1, B+'h18, word(B+'h18)));
        vecs.push_back(mk(1, B+'h1C,   1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(B+'h1C), 0, 0, 0, 1, B+'h1C, word(B+'h1C)));
        vecs.push_back(mk(1, B+'h20,   1, 0, 0, 0, 0, 0, 0, 0, 0));
        // redirect to 0x103 while waiting on 0x20; its response comes 3 cycles later
        vecs.push_back(mk(0, 0,        0, 0, 0, 0, 1, 32'h103, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(B+'h20), 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h100,  1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(32'h100), 0, 0, 0, 1, 32'h100, word(32'h100)));
        // redirect in the same cycle as a grant
        vecs.push_back(mk(1, 32'h104,  1, 0, 0, 0, 1, 32'h8, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(32'h104), 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8,    1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,        0, 1, word(32'h8), 0, 0, 0, 1, 32'h8, word(32'h8)));

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Redirect under stall: outputs still clear
        applyStimulus(mk(1, 32'hC, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rs0");
        applyStimulus(mk(0, 0, 0, 1, word(32'hC), 0, 0, 0, 1, 32'hC, word(32'hC)), "rs1");
        applyStimulus(mk(1, 32'h10, 0, 0, 0, 1, 1, 32'h40, 0, 0, 0), "rs2 stalled redirect");
        applyStimulus(mk(1, 32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rs3");
        applyStimulus(mk(0, 0, 0, 1, word(32'h40), 0, 0, 0, 1, 32'h40, word(32'h40)), "rs4");

        // Reset while waiting, then a stale rvalid right after reset release
        applyStimulus(mk(1, 32'h44, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rw0");
        applyStimulus(mk(0, 0, 0, 1, word(32'h44), 0, 0, 0, 1, 32'h44, word(32'h44)), "rw1");
        applyStimulus(mk(1, 32'h48, 1, 0, 0, 1, 0, 0, 1, 32'h44, word(32'h44)), "rw2");
        idleInputs();
        stall = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("rw3 req in reset", {31'h0, imem_req}, 32'h0);
        @(posedge clk); #1;
        checkOutput("rw3 valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rw3 pc", pc, 32'h0);
        checkOutput("rw3 instr", instruction, 32'h0);
        reset = 1'b0;
        applyStimulus(mk(1, RST, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0), "rw4 late rvalid");
        applyStimulus(mk(1, RST, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rw5");
        applyStimulus(mk(0, 0, 0, 1, word(RST), 0, 0, 0, 1, RST, word(RST)), "rw6");

        // Randomized run against a fetch-stream model
        idleInputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_req_addr = RST; exp_out_pc = RST; outstanding = 0; lat = 0;
        prev_stall = 0; prev_load = 0; valid_seen = 0;
        held_pc = 0; held_instr = 0; held_valid = 0; out_addr = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_load) begin
                checkOutput("rnd redirect valid", {31'h0, instr_valid}, 32'h0);
                checkOutput("rnd redirect pc", pc, 32'h0);
                checkOutput("rnd redirect instr", instruction, 32'h0);
            end else if (prev_stall) begin
                checkOutput("rnd hold valid", {31'h0, instr_valid}, {31'h0, held_valid});
                checkOutput("rnd hold pc", pc, held_pc);
                checkOutput("rnd hold instr", instruction, held_instr);
            end else if (instr_valid) begin
                checkOutput("rnd stream pc", pc, exp_out_pc);
                checkOutput("rnd stream instr", instruction, word(exp_out_pc));
                exp_out_pc = exp_out_pc + 32'd4;
                valid_seen++;
            end else begin
                checkOutput("rnd bubble pc", pc, 32'h0);
                checkOutput("rnd bubble instr", instruction, 32'h0);
            end
            held_pc = pc; held_instr = instruction; held_valid = instr_valid;

            busy = outstanding;
            rvalid = 0; rdata = 32'h0;
            if (outstanding) begin
                if (lat == 0) begin
                    rvalid = 1; rdata = word(out_addr); outstanding = 0;
                end else begin
                    lat--;
                end
            end
            stall  = ($urandom % 4) == 0;
            load   = ($urandom % 16) == 0;
            new_pc = $urandom & 32'h0000_FFFF;
            gnt    = ($urandom % 4) != 0;
            #1;
            if (imem_req) begin
                checkOutput("rnd single outstanding", {31'h0, busy}, 32'h0);
                checkOutput("rnd req addr", imem_addr, exp_req_addr);
            end
            if (imem_req && gnt) begin
                outstanding = 1;
                out_addr = imem_addr;
                lat = $urandom_range(0, 2);
                exp_req_addr = exp_req_addr + 32'd4;
            end
            if (load) begin
                exp_req_addr = new_pc & ~32'd3;
                exp_out_pc   = new_pc & ~32'd3;
            end
            prev_stall = stall;
            prev_load  = load;
            @(posedge clk); #1;
        end
        checkOutput("rnd progress", {31'h0, valid_seen > 100}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
